sa_tile_ctrl: RTL
=================

// Module: sa_tile_ctrl
// PURPOSE
//   Sequencer for one output tile of the SIDE x SIDE PE array.
//   - Accepts a tile command (reduction length K) over valid/ready.
//   - Streams K operand reads from the A/B buffers into the array, then flushes the skewed wavefront.
//   - Drains SIDE result rows under backpressure and pulses done.
//   - Sits between the AXI-side command/buffer logic and the PE array.
// PARAMETERS
//   SIDE       8   array dimension (rows == cols), >= 2
//   KLEN_BITS  16  width of cmd_k_len; max K = 2**KLEN_BITS-1
//   RD_LAT     1   operand buffer read latency in cycles, 1..4
// PORTS
//   clk            in   1                  clock, all logic on rising edge
//   rst            in   1                  synchronous reset, active-high
//   cmd_valid      in   1                  tile command valid
//   cmd_ready      out  1                  controller can accept command (IDLE only)
//   cmd_k_len      in   KLEN_BITS          reduction length K
//   cmd_acc_clr    in   1                  clear PE accumulators at tile start
//   buf_rd_en      out  1                  operand buffer read strobe
//   buf_rd_addr    out  KLEN_BITS          operand buffer address (k index)
//   pe_feed_valid  out  1                  operands on a_bus/b_bus are valid this cycle
//   pe_acc_clr     out  1                  one-cycle accumulator clear pulse
//   pe_drain       out  1                  array shifts out one result row
//   drain_row      out  $clog2(SIDE)       index of row being presented
//   res_valid      out  1                  result row valid toward writeback
//   res_ready      in   1                  writeback accepts row
//   busy           out  1                  high in every state except IDLE
//   done           out  1                  one-cycle tile-complete pulse
//   err_zero_len   out  1                  one-cycle pulse, command had K==0
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except cmd_ready=1; counters and delay line cleared.
//   Reset mid-tile: abandon tile, in-flight reads/feeds dropped, no done pulse.
//   States IDLE -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
//   IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready; latch K and acc_clr.
//     K==0: go to DONE directly; err_zero_len pulses in the DONE cycle together with done.
//   FEED: exactly K cycles, buf_rd_en=1, buf_rd_addr = 0,1,..,K-1 (one per cycle, no stall).
//     pe_acc_clr=1 in the first FEED cycle iff latched acc_clr.
//     pe_feed_valid = buf_rd_en delayed by RD_LAT cycles (shift register).
//   FLUSH: exactly 2*(SIDE-1)+RD_LAT cycles; buf_rd_en=0.
//     The last RD_LAT-delayed feeds land here. The wavefront then propagates with zero-valued bubbles.
//   DRAIN: res_valid=1, drain_row starts at 0.
//     Beat on res_valid&res_ready: pe_drain=1 that cycle, drain_row++.
//     Stall (res_ready=0): hold res_valid, drain_row; pe_drain=0.
//     After beat with drain_row==SIDE-1 -> DONE.
//   DONE: done=1 for one cycle, busy=1; next cycle IDLE. cmd_ready=0 in DONE.
//   Latency, accept to done, no stalls: K + 2*(SIDE-1) + RD_LAT + SIDE + 1 cycles.
//   The +1 is the DONE cycle. Accept cycle is in IDLE and not counted.
//   Counters: k counter KLEN_BITS wide, never wraps (stops at K-1).
//     Flush counter sized for max flush length. Row counter saturates at SIDE-1.
//   cmd_valid while busy: ignored (cmd_ready=0); command stays pending at source.
//   Back-to-back: new command accepted the cycle after DONE (IDLE), earliest.
// CONFIGURATION
//   SA_CTRL_PERF_EN defined:
//     Adds output perf_cycles [31:0]: counts cycles with busy=1, includes DONE.
//     Adds output perf_stalls [31:0]: counts DRAIN cycles with res_ready=0.
//     Both clear on rst and on command accept; saturate at 2**32-1; hold value in IDLE.
//   Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   1. rst held 3 cycles -> cmd_ready=1, busy=0, done=0, all strobes 0.
//   2. SIDE=8,RD_LAT=1,K=4,acc_clr=1,res_ready=1:
//      - addrs 0..3 on 4 cycles; pe_acc_clr with addr 0.
//      - feed_valid 1 cycle later; 15 flush cycles; 8 drain beats rows 0..7.
//      - done 28 cycles after accept.
//   3. K=0 -> done and err_zero_len pulse together, exactly 1 cycle after accept; no rd/feed/drain.
//   4. K=2, res_ready low 5 cycles at row 3 -> res_valid held, drain_row=3, no pe_drain.
//      Done delayed by exactly 5 cycles (perf_stalls=5 with SA_CTRL_PERF_EN).
//   5. rst asserted mid-FEED (addr 2 of K=10) -> next cycle IDLE, cmd_ready=1, no done.
//      A new K=1 command then completes normally.
//   6. cmd_valid held high continuously with K=1 -> accepts spaced exactly 1 IDLE cycle after each done.
//      cmd_ready never high while busy.

Source files
------------

// File: rtl/sa_tile_ctrl_if.sv
// Command / operand-buffer / PE-array / writeback signal bundle for sa_tile_ctrl.
// master: command source and writeback sink side; slave: the tile controller.
interface sa_tile_ctrl_if #(
  parameter int SIDE      = 8,
  parameter int KLEN_BITS = 16
);
  localparam int ROW_W = $clog2(SIDE);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [KLEN_BITS-1:0] cmd_k_len;
  logic                 cmd_acc_clr;
  logic                 buf_rd_en;
  logic [KLEN_BITS-1:0] buf_rd_addr;
  logic                 pe_feed_valid;
  logic                 pe_acc_clr;
  logic                 pe_drain;
  logic [ROW_W-1:0]     drain_row;
  logic                 res_valid;
  logic                 res_ready;
  logic                 busy;
  logic                 done;
  logic                 err_zero_len;

  modport slave (
    input  cmd_valid, cmd_k_len, cmd_acc_clr, res_ready,
    output cmd_ready, buf_rd_en, buf_rd_addr, pe_feed_valid, pe_acc_clr,
           pe_drain, drain_row, res_valid, busy, done, err_zero_len
  );

  modport master (
    output cmd_valid, cmd_k_len, cmd_acc_clr, res_ready,
    input  cmd_ready, buf_rd_en, buf_rd_addr, pe_feed_valid, pe_acc_clr,
           pe_drain, drain_row, res_valid, busy, done, err_zero_len
  );
endinterface

// File: rtl/sa_tile_ctrl.sv
// Tile sequencer for a SIDE x SIDE systolic PE array: accepts a command of
// reduction length K, streams K operand reads, flushes the skewed wavefront,
// drains SIDE result rows under backpressure and pulses done.
// Optional build macro SA_CTRL_PERF_EN adds perf_cycles / perf_stalls counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cmd_ready=1, waiting for a tile command
// S_FEED  | K cycles of operand reads, addr 0..K-1
// S_FLUSH | 2*(SIDE-1)+RD_LAT cycles for delayed feeds and skew to settle
// S_DRAIN | present result rows 0..SIDE-1, one per res_valid&res_ready
// S_DONE  | one-cycle done pulse (err_zero_len too if K was 0)
module sa_tile_ctrl #(
  parameter int SIDE      = 8,
  parameter int KLEN_BITS = 16,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  sa_tile_ctrl_if.slave bus
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stalls
`endif
);

  localparam int ROW_W     = $clog2(SIDE);
  localparam int FLUSH_LEN = 2 * (SIDE - 1) + RD_LAT;
  localparam int FL_W      = $clog2(FLUSH_LEN);

  localparam logic [FL_W-1:0]      FL_LOAD  = FL_W'(FLUSH_LEN - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(SIDE - 1);
  localparam logic [ROW_W-1:0]     ROW_ONE  = ROW_W'(1);
  localparam logic [KLEN_BITS-1:0] K_ONE    = KLEN_BITS'(1);
  localparam logic [FL_W-1:0]      FL_ONE   = FL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [KLEN_BITS-1:0] r_k_last;
  logic [KLEN_BITS-1:0] r_k_cnt;
  logic                 r_acc_clr;
  logic                 r_zero;
  logic [FL_W-1:0]      r_fl_cnt;
  logic [ROW_W-1:0]     r_row;
  logic [RD_LAT-1:0]    r_dly;

  logic w_accept;
  logic w_cmd_ready;
  logic w_rd_en;
  logic w_acc_clr_p;
  logic w_drain;
  logic w_res_valid;
  logic w_done;
  logic w_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and Moore/Mealy outputs
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_rd_en     = 1'b0;
    w_acc_clr_p = 1'b0;
    w_drain     = 1'b0;
    w_res_valid = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_next = (bus.cmd_k_len == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        w_rd_en     = 1'b1;
        w_acc_clr_p = r_acc_clr && (r_k_cnt == '0);
        if (r_k_cnt == r_k_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_fl_cnt == '0) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_res_valid = 1'b1;
        w_drain     = bus.res_ready;
        if (bus.res_ready && (r_row == ROW_LAST)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_err  = r_zero;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = w_cmd_ready && bus.cmd_valid;

  // Command latch, k / flush / row counters and the read-to-feed delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k_last  <= '0;
      r_k_cnt   <= '0;
      r_acc_clr <= 1'b0;
      r_zero    <= 1'b0;
      r_fl_cnt  <= '0;
      r_row     <= '0;
      r_dly     <= '0;
    end else begin
      if (w_accept) begin
        r_k_last  <= bus.cmd_k_len - K_ONE;
        r_acc_clr <= bus.cmd_acc_clr;
        r_zero    <= (bus.cmd_k_len == '0);
        r_k_cnt   <= '0;
        r_row     <= '0;
      end
      // k index stops at K-1 so a maximal K never wraps the address
      if ((r_state == S_FEED) && (r_k_cnt != r_k_last)) r_k_cnt <= r_k_cnt + K_ONE;
      if (r_state == S_DONE) begin
        r_k_cnt <= '0;
        r_row   <= '0;
      end
      // flush timer: loaded throughout FEED, counts down to terminal 0 in FLUSH
      if (r_state == S_FEED)                         r_fl_cnt <= FL_LOAD;
      else if ((r_state == S_FLUSH) && (r_fl_cnt != '0)) r_fl_cnt <= r_fl_cnt - FL_ONE;
      if (w_drain && (r_row != ROW_LAST)) r_row <= r_row + ROW_ONE;
      r_dly[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign bus.cmd_ready     = w_cmd_ready;
  assign bus.buf_rd_en     = w_rd_en;
  assign bus.buf_rd_addr   = r_k_cnt;
  assign bus.pe_feed_valid = r_dly[RD_LAT-1];
  assign bus.pe_acc_clr    = w_acc_clr_p;
  assign bus.pe_drain      = w_drain;
  assign bus.drain_row     = r_row;
  assign bus.res_valid     = w_res_valid;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = w_done;
  assign bus.err_zero_len  = w_err;

`ifdef SA_CTRL_PERF_EN
  // Saturating busy-cycle and drain-stall counters, cleared on accept
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if ((r_state != S_IDLE) && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
      if ((r_state == S_DRAIN) && !bus.res_ready && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
